// File: rtl/stream_check_pkg.sv
// Shared types and arithmetic helpers for the stream result checker.
// Helpers take width/signedness as arguments so one body serves any lane width up to MAX_W.
package stream_check_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // |a-b| evaluated in w+1 bits; the operands are sign- or zero-extended from bit w-1.
  function automatic logic [MAX_W:0] lane_abs_diff(input logic [MAX_W-1:0] a,
                                                   input logic [MAX_W-1:0] b,
                                                   input int unsigned w,
                                                   input bit is_signed);
    logic [MAX_W:0] mask;
    logic [MAX_W:0] ext_a;
    logic [MAX_W:0] ext_b;
    logic [MAX_W:0] diff;
    mask  = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
    ext_a = {1'b0, a} & mask;
    ext_b = {1'b0, b} & mask;
    if (is_signed && (((a >> (w - 1)) & MAX_W'(1)) != '0)) ext_a = ext_a | ~mask;
    if (is_signed && (((b >> (w - 1)) & MAX_W'(1)) != '0)) ext_b = ext_b | ~mask;
    diff = ext_a - ext_b;
    return diff[MAX_W] ? (~diff + (MAX_W+1)'(1)) : diff;
  endfunction

  function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] v,
                                               input int unsigned w);
    logic [MAX_W-1:0] top;
    top = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    return (v >= top) ? v : v + MAX_W'(1);
  endfunction

endpackage

// File: rtl/stream_result_checker_fifo.sv
// Expected-data FIFO: power-of-two depth, extra pointer bit separates full from empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/stream_result_checker.sv
// Pairs queued expected beats with DUT output beats, reports per-lane error and
// running statistics, and produces a pass verdict once draining completes.
module stream_result_checker
  import stream_check_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int LANES   = 1,
  parameter int DEPTH   = 8,
  parameter int TOL     = 0,
  parameter int SIGNED  = 1,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clear,
  input  logic                    i_finish,
  input  logic                    i_exp_valid,
  output logic                    o_exp_ready,
  input  logic [LANES*DATA_W-1:0] i_exp_data,
  input  logic                    i_act_valid,
  input  logic [LANES*DATA_W-1:0] i_act_data,
  output logic                    o_err_valid,
  output logic [LANES*DATA_W-1:0] o_err_data,
  output logic [LANES-1:0]        o_err_lane_mis,
  output logic [CNT_W-1:0]        o_sample_cnt,
  output logic [CNT_W-1:0]        o_mismatch_cnt,
  output logic [DATA_W:0]         o_max_abs_err,
  output logic                    o_underflow,
  output logic                    o_timeout,
  output logic                    o_done,
  output logic                    o_pass
);

  localparam int W  = LANES * DATA_W;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           r_state;
  logic             r_ready_en;
  logic             r_err_valid;
  logic [W-1:0]     r_err_data;
  logic [LANES-1:0] r_err_lane_mis;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_mismatch_cnt;
  logic [DATA_W:0]  r_max_abs_err;
  logic             r_underflow;
  logic             r_timeout;
  logic [TW-1:0]    r_idle_cnt;

  logic             w_full;
  logic             w_empty;
  logic [W-1:0]     w_head;
  logic             w_push;
  logic             w_pop;
  logic [W-1:0]     w_err;
  logic [LANES-1:0] w_mis;
  logic [DATA_W:0]  w_lane_abs;
  logic [DATA_W:0]  w_max_abs;

  // r_ready_en keeps exp_ready low for the first cycle after reset or clear.
  assign o_exp_ready = r_ready_en && !w_full && (r_state != DONE);
  assign w_push      = i_exp_valid && o_exp_ready && !i_clear;
  assign w_pop       = i_act_valid && !w_empty && (r_state != DONE) && !i_clear;

  sync_fifo #(
    .WIDTH(W),
    .DEPTH(DEPTH)
  ) u_exp_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_flush(i_clear),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_data (i_exp_data),
    .o_head (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_comb begin
    w_err      = '0;
    w_mis      = '0;
    w_lane_abs = '0;
    w_max_abs  = '0;
    for (int i = 0; i < LANES; i++) begin
      w_err[i*DATA_W +: DATA_W] = w_head[i*DATA_W +: DATA_W] - i_act_data[i*DATA_W +: DATA_W];
      w_lane_abs = (DATA_W+1)'(lane_abs_diff(MAX_W'(w_head[i*DATA_W +: DATA_W]),
                                             MAX_W'(i_act_data[i*DATA_W +: DATA_W]),
                                             DATA_W, SIGNED != 0));
      w_mis[i]   = w_lane_abs > (DATA_W+1)'(TOL);
      if (w_lane_abs > w_max_abs) w_max_abs = w_lane_abs;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst || i_clear) begin
      r_state        <= IDLE;
      r_ready_en     <= 1'b0;
      r_err_valid    <= 1'b0;
      r_err_data     <= '0;
      r_err_lane_mis <= '0;
      r_sample_cnt   <= '0;
      r_mismatch_cnt <= '0;
      r_max_abs_err  <= '0;
      r_underflow    <= 1'b0;
      r_timeout      <= 1'b0;
      r_idle_cnt     <= '0;
    end else begin
      r_ready_en  <= 1'b1;
      r_err_valid <= w_pop;
      if (w_pop) begin
        r_err_data     <= w_err;
        r_err_lane_mis <= w_mis;
        r_sample_cnt   <= CNT_W'(sat_inc(MAX_W'(r_sample_cnt), CNT_W));
        if (|w_mis) r_mismatch_cnt <= CNT_W'(sat_inc(MAX_W'(r_mismatch_cnt), CNT_W));
        if (w_max_abs > r_max_abs_err) r_max_abs_err <= w_max_abs;
      end
      if (i_act_valid && (w_empty || r_state == DONE)) r_underflow <= 1'b1;

      case (r_state)
        IDLE: begin
          if (i_finish) begin
            r_state    <= DRAIN;
            r_idle_cnt <= '0;
          end else if (w_push || i_act_valid) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (i_finish) begin
            r_state    <= DRAIN;
            r_idle_cnt <= '0;
          end
        end
        DRAIN: begin
          // A same-cycle push keeps us draining so the new entry is still checked.
          if (w_empty && !w_push) begin
            r_state <= DONE;
          end else if (w_pop) begin
            r_idle_cnt <= '0;
          end else if (r_idle_cnt == TW'(TIMEOUT - 1)) begin
            r_state   <= DONE;
            r_timeout <= 1'b1;
          end else begin
            r_idle_cnt <= r_idle_cnt + TW'(1);
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_err_valid    = r_err_valid;
  assign o_err_data     = r_err_data;
  assign o_err_lane_mis = r_err_lane_mis;
  assign o_sample_cnt   = r_sample_cnt;
  assign o_mismatch_cnt = r_mismatch_cnt;
  assign o_max_abs_err  = r_max_abs_err;
  assign o_underflow    = r_underflow;
  assign o_timeout      = r_timeout;
  assign o_done         = (r_state == DONE);
  assign o_pass         = o_done && (r_mismatch_cnt == '0) && !r_underflow && !r_timeout;

endmodule

// File: tb/tb_stream_result_checker.sv
// Scoreboard bench: a signed and an unsigned checker instance, directed vectors,
// expected error beats queued at issue time and consumed by per-instance monitors.
module tb_stream_result_checker;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] err;
    logic [1:0]   mis;
    int           cycle;
  } score_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic finish = 1'b0;

  logic         sExpValid = 1'b0;
  logic [W-1:0] sExpData = '0;
  logic         sActValid = 1'b0;
  logic [W-1:0] sActData = '0;
  logic         sExpReady, sErrValid, sUnderflow, sTimeout, sDone, sPass;
  logic [W-1:0] sErrData;
  logic [1:0]   sErrLaneMis;
  logic [31:0]  sSampleCnt, sMismatchCnt;
  logic [16:0]  sMaxAbsErr;

  logic         uExpValid = 1'b0;
  logic [W-1:0] uExpData = '0;
  logic         uActValid = 1'b0;
  logic [W-1:0] uActData = '0;
  logic         uExpReady, uErrValid, uUnderflow, uTimeout, uDone, uPass;
  logic [W-1:0] uErrData;
  logic [1:0]   uErrLaneMis;
  logic [31:0]  uSampleCnt, uMismatchCnt;
  logic [16:0]  uMaxAbsErr;

  int checkCount = 0;
  int failCount = 0;
  int cycleCount = 0;
  score_t sQ[$];
  score_t uQ[$];
  score_t sEntry;
  score_t uEntry;

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  stream_result_checker #(
    .DATA_W(16), .LANES(2), .DEPTH(4), .TOL(1), .SIGNED(1), .CNT_W(32), .TIMEOUT(16)
  ) dutSigned (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_finish(finish),
    .i_exp_valid(sExpValid), .o_exp_ready(sExpReady), .i_exp_data(sExpData),
    .i_act_valid(sActValid), .i_act_data(sActData),
    .o_err_valid(sErrValid), .o_err_data(sErrData), .o_err_lane_mis(sErrLaneMis),
    .o_sample_cnt(sSampleCnt), .o_mismatch_cnt(sMismatchCnt), .o_max_abs_err(sMaxAbsErr),
    .o_underflow(sUnderflow), .o_timeout(sTimeout), .o_done(sDone), .o_pass(sPass)
  );

  stream_result_checker #(
    .DATA_W(16), .LANES(2), .DEPTH(4), .TOL(1), .SIGNED(0), .CNT_W(32), .TIMEOUT(16)
  ) dutUnsigned (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_finish(1'b0),
    .i_exp_valid(uExpValid), .o_exp_ready(uExpReady), .i_exp_data(uExpData),
    .i_act_valid(uActValid), .i_act_data(uActData),
    .o_err_valid(uErrValid), .o_err_data(uErrData), .o_err_lane_mis(uErrLaneMis),
    .o_sample_cnt(uSampleCnt), .o_mismatch_cnt(uMismatchCnt), .o_max_abs_err(uMaxAbsErr),
    .o_underflow(uUnderflow), .o_timeout(uTimeout), .o_done(uDone), .o_pass(uPass)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of stimulus; a scored act beat queues its hand-computed result.
  task automatic applyStimulus(input bit toUnsigned, input bit expV, input logic [W-1:0] expD,
                               input bit actV, input logic [W-1:0] actD, input bit scored,
                               input logic [W-1:0] errD, input logic [1:0] mis);
    score_t e;
    if (toUnsigned) begin
      uExpValid = expV; uExpData = expD; uActValid = actV; uActData = actD;
    end else begin
      sExpValid = expV; sExpData = expD; sActValid = actV; sActData = actD;
    end
    if (actV && scored) begin
      e.err = errD;
      e.mis = mis;
      e.cycle = cycleCount + 1;
      if (toUnsigned) uQ.push_back(e);
      else sQ.push_back(e);
    end
    @(posedge clk);
    #1;
    sExpValid = 1'b0; sActValid = 1'b0; uExpValid = 1'b0; uActValid = 1'b0;
  endtask

  task automatic applyControl(input bit clr, input bit fin);
    clear = clr;
    finish = fin;
    @(posedge clk);
    #1;
    clear = 1'b0;
    finish = 1'b0;
  endtask

  task automatic pushBeat(input logic [W-1:0] d);
    applyStimulus(1'b0, 1'b1, d, 1'b0, '0, 1'b0, '0, 2'b00);
  endtask

  task automatic popBeat(input logic [W-1:0] a, input logic [W-1:0] err, input logic [1:0] mis);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, a, 1'b1, err, mis);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 2'b00);
  endtask

  always @(negedge clk) begin
    if (sErrValid) begin
      if (sQ.size() == 0) begin
        checkOutput("sErrValidSpurious", sErrValid, 1'b0);
      end else begin
        sEntry = sQ.pop_front();
        checkOutput("sErrData", sErrData, sEntry.err);
        checkOutput("sErrLaneMis", sErrLaneMis, sEntry.mis);
        checkOutput("sErrLatency", cycleCount, sEntry.cycle);
      end
    end
  end

  always @(negedge clk) begin
    if (uErrValid) begin
      if (uQ.size() == 0) begin
        checkOutput("uErrValidSpurious", uErrValid, 1'b0);
      end else begin
        uEntry = uQ.pop_front();
        checkOutput("uErrData", uErrData, uEntry.err);
        checkOutput("uErrLaneMis", uErrLaneMis, uEntry.mis);
        checkOutput("uErrLatency", cycleCount, uEntry.cycle);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstExpReady", sExpReady, 1'b0);
    checkOutput("rstDone", sDone, 1'b0);
    checkOutput("rstPass", sPass, 1'b0);
    rst = 1'b0;
    checkOutput("rstReleaseExpReady", sExpReady, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("postRstExpReady", sExpReady, 1'b1);

    // Reset with three entries queued in RUN.
    repeat (3) pushBeat({16'h0003, 16'h0010});
    checkOutput("runExpReady", sExpReady, 1'b1);
    rst = 1'b1;
    #2;
    checkOutput("midRstExpReady", sExpReady, 1'b0);
    checkOutput("midRstSample", sSampleCnt, 0);
    checkOutput("midRstUnderflow", sUnderflow, 1'b0);
    checkOutput("midRstErrValid", sErrValid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("afterRstExpReady", sExpReady, 1'b1);
    applyControl(1'b0, 1'b1);
    idleCycle();
    checkOutput("afterRstEmptyDone", sDone, 1'b1);
    checkOutput("afterRstEmptyPass", sPass, 1'b1);
    checkOutput("doneExpReady", sExpReady, 1'b0);

    // Same scenario with clear.
    applyControl(1'b1, 1'b0);
    checkOutput("clearDoneExit", sDone, 1'b0);
    idleCycle();
    repeat (3) pushBeat({16'h0003, 16'h0010});
    applyControl(1'b1, 1'b0);
    checkOutput("midClearExpReady", sExpReady, 1'b0);
    checkOutput("midClearDone", sDone, 1'b0);
    idleCycle();
    checkOutput("afterClearExpReady", sExpReady, 1'b1);
    applyControl(1'b0, 1'b1);
    idleCycle();
    checkOutput("afterClearEmptyDone", sDone, 1'b1);
    checkOutput("afterClearEmptyPass", sPass, 1'b1);

    // Exact match.
    applyControl(1'b1, 1'b0);
    idleCycle();
    repeat (3) pushBeat({16'h0003, 16'h0010});
    repeat (3) popBeat({16'h0003, 16'h0010}, '0, 2'b00);
    idleCycle();
    checkOutput("exactSample", sSampleCnt, 3);
    checkOutput("exactMismatch", sMismatchCnt, 0);
    checkOutput("exactMaxAbs", sMaxAbsErr, 0);
    applyControl(1'b0, 1'b1);
    idleCycle();
    checkOutput("exactDone", sDone, 1'b1);
    checkOutput("exactPass", sPass, 1'b1);

    // Tolerance band and signed wrap.
    applyControl(1'b1, 1'b0);
    idleCycle();
    pushBeat({16'h0004, 16'h0005});
    pushBeat({16'h0005, 16'h0010});
    pushBeat({16'h0000, 16'h7FFF});
    popBeat({16'h0005, 16'h0004}, {16'hFFFF, 16'h0001}, 2'b00);
    checkOutput("tolMaxAbs1", sMaxAbsErr, 17'h00001);
    checkOutput("tolMismatch0", sMismatchCnt, 0);
    popBeat({16'h0002, 16'h0010}, {16'h0003, 16'h0000}, 2'b10);
    checkOutput("tolMaxAbs3", sMaxAbsErr, 17'h00003);
    checkOutput("tolMismatch1", sMismatchCnt, 1);
    popBeat({16'h0000, 16'h8000}, {16'h0000, 16'hFFFF}, 2'b01);
    checkOutput("wrapMaxAbs", sMaxAbsErr, 17'h0FFFF);
    checkOutput("wrapMismatch", sMismatchCnt, 2);
    checkOutput("wrapSample", sSampleCnt, 3);
    applyControl(1'b0, 1'b1);
    idleCycle();
    checkOutput("tolDone", sDone, 1'b1);
    checkOutput("tolPass", sPass, 1'b0);

    // Unsigned lanes: same wrap pair is a distance of one.
    applyControl(1'b1, 1'b0);
    idleCycle();
    applyStimulus(1'b1, 1'b1, {16'h0000, 16'h7FFF}, 1'b0, '0, 1'b0, '0, 2'b00);
    applyStimulus(1'b1, 1'b1, {16'h0000, 16'h0003}, 1'b0, '0, 1'b0, '0, 2'b00);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, {16'h0000, 16'h8000}, 1'b1, {16'h0000, 16'hFFFF}, 2'b00);
    checkOutput("uMaxAbs1", uMaxAbsErr, 17'h00001);
    checkOutput("uMismatch0", uMismatchCnt, 0);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, {16'hFFFF, 16'h0003}, 1'b1, {16'h0001, 16'h0000}, 2'b10);
    checkOutput("uMaxAbsFull", uMaxAbsErr, 17'h0FFFF);
    checkOutput("uMismatch1", uMismatchCnt, 1);
    checkOutput("uSample", uSampleCnt, 2);

    // Full FIFO stall, pop-while-full, and push+pop at occupancy two.
    applyControl(1'b1, 1'b0);
    idleCycle();
    for (int k = 1; k <= 4; k++) begin
      checkOutput("fillExpReady", sExpReady, 1'b1);
      pushBeat({16'h0000, 16'(k * 16'h11)});
    end
    checkOutput("fullStall", sExpReady, 1'b0);
    pushBeat({16'h0000, 16'h0055});
    checkOutput("fullPopStall", sExpReady, 1'b0);
    applyStimulus(1'b0, 1'b1, {16'h0000, 16'h0055}, 1'b1, '0, 1'b1, {16'h0000, 16'h0011}, 2'b01);
    checkOutput("freedExpReady", sExpReady, 1'b1);
    pushBeat({16'h0000, 16'h0055});
    popBeat('0, {16'h0000, 16'h0022}, 2'b01);
    popBeat('0, {16'h0000, 16'h0033}, 2'b01);
    applyStimulus(1'b0, 1'b1, {16'h0000, 16'h0066}, 1'b1, '0, 1'b1, {16'h0000, 16'h0044}, 2'b01);
    checkOutput("occ2ExpReady", sExpReady, 1'b1);
    pushBeat({16'h0000, 16'h0077});
    checkOutput("occ3ExpReady", sExpReady, 1'b1);
    pushBeat({16'h0000, 16'h0088});
    checkOutput("occ4ExpReady", sExpReady, 1'b0);
    for (int k = 5; k <= 8; k++) popBeat('0, {16'h0000, 16'(k * 16'h11)}, 2'b01);
    idleCycle();
    checkOutput("fullSample", sSampleCnt, 8);
    checkOutput("fullMismatch", sMismatchCnt, 8);
    checkOutput("fullMaxAbs", sMaxAbsErr, 17'h00088);

    // Underflow.
    applyControl(1'b1, 1'b0);
    idleCycle();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, {16'h1234, 16'h5678}, 1'b0, '0, 2'b00);
    checkOutput("underflowFlag", sUnderflow, 1'b1);
    checkOutput("underflowSample", sSampleCnt, 0);
    checkOutput("underflowErrValid", sErrValid, 1'b0);
    applyControl(1'b0, 1'b1);
    idleCycle();
    checkOutput("underflowDone", sDone, 1'b1);
    checkOutput("underflowPass", sPass, 1'b0);

    // Drain timeout, restarted by a pop on the tenth drain cycle.
    applyControl(1'b1, 1'b0);
    idleCycle();
    pushBeat({16'h0000, 16'h0011});
    pushBeat({16'h0000, 16'h0022});
    applyControl(1'b0, 1'b1);
    repeat (9) idleCycle();
    checkOutput("drainEarlyDone", sDone, 1'b0);
    popBeat({16'h0000, 16'h0011}, '0, 2'b00);
    repeat (15) idleCycle();
    checkOutput("drain15Done", sDone, 1'b0);
    checkOutput("drain15Timeout", sTimeout, 1'b0);
    idleCycle();
    checkOutput("timeoutDone", sDone, 1'b1);
    checkOutput("timeoutFlag", sTimeout, 1'b1);
    checkOutput("timeoutPass", sPass, 1'b0);

    repeat (2) idleCycle();
    checkOutput("sQueueDrained", sQ.size(), 0);
    checkOutput("uQueueDrained", uQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/stream_result_checker.md
Name: stream_result_checker

Overview:
- Synthesizable successor to the single-port x/y compare flow: queues expected vectors, pairs each with the next DUT output beat, and computes per-lane error as expected minus actual.
- Generalised to LANES channels, a latency-tolerant expected FIFO, signed/unsigned modes, a tolerance band, running statistics and a finish/drain state machine with a pass verdict.
- Sits between the stimulus source and the accelerator output stream in simulation and FPGA self-test builds.

Parameters:
- DATA_W, 16, bits per lane.
- LANES, 1, parallel channels per beat.
- DEPTH, 8, expected-FIFO entries (power of two, ≥2).
- TOL, 0, maximum allowed |error| per lane.
- SIGNED, 1, 1 = lanes are two's complement, 0 = unsigned.
- CNT_W, 32, statistics counter width.
- TIMEOUT, 1024, drain cycles without a pop before forced DONE.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-high.
- clear  in  1  synchronous restart. Highest priority after rst.
- finish  in  1  single-cycle pulse: no more expected data.
- exp_valid  in  1  expected beat valid.
- exp_ready  out  1  FIFO can accept.
- exp_data  in  LANES*DATA_W  expected lanes; lane i = bits [i*DATA_W +: DATA_W].
- act_valid  in  1  DUT output beat. No backpressure.
- act_data  in  LANES*DATA_W  DUT output lanes.
- err_valid  out  1  error result valid.
- err_data  out  LANES*DATA_W  (exp-act) mod 2^DATA_W per lane.
- err_lane_mis  out  LANES  per-lane |err|>TOL.
- sample_cnt  out  CNT_W  beats compared.
- mismatch_cnt  out  CNT_W  beats with any lane mismatch.
- max_abs_err  out  DATA_W+1  largest |err| seen over all lanes.
- underflow  out  1  sticky: act beat arrived with FIFO empty.
- timeout  out  1  sticky: drain timed out.
- done  out  1  in DONE state.
- pass  out  1  done & mismatch_cnt==0 & !underflow & !timeout.

Behaviour:
- Reset (rst or clear): all outputs 0, FIFO empty, state IDLE. exp_ready becomes 1 the cycle after reset/clear deasserts.
- Push:
  - exp_ready = !full & state!=DONE; push on exp_valid&exp_ready.
  - exp_ready does not depend on a same-cycle pop; a full FIFO refuses the push even when popping.
- Pop:
  - act_valid & !empty pops the head.
  - Per lane: d = exp-act computed in DATA_W+1 bits with sign extension (SIGNED=1) or zero extension (SIGNED=0). abs = |d|. mis = abs>TOL.
  - Latency 1: err_valid, err_data (low DATA_W bits of d) and err_lane_mis are registered and appear the next cycle. err_valid is 0 otherwise; the other result outputs hold.
  - Same edge as err_valid: sample_cnt+1, mismatch_cnt+1 if |mis, max_abs_err updated with the largest lane abs. Counters saturate at all-ones.
- act_valid & empty (any state): underflow:=1. No pop, no err_valid, counters unchanged.
- Simultaneous push and pop on a non-empty FIFO: occupancy unchanged, order preserved.
- FSM:
  - IDLE -> RUN on first push or act_valid.
  - IDLE/RUN -> DRAIN on finish.
  - DRAIN -> DONE when FIFO is empty.
  - DRAIN -> DONE, timeout:=1, when TIMEOUT consecutive cycles pass without a pop; the idle counter resets on every pop.
  - DONE holds until rst or clear.
  - finish in DRAIN/DONE is ignored.
  - In DONE, act_valid only sets underflow.
- pass and done are combinational from registered state; pass is 0 whenever done=0.

Decomposition:
- Package stream_check_pkg: state enum (IDLE, RUN, DRAIN, DONE), lane_abs_diff function (width and signedness parameterised through arguments), saturating-increment function.
- Sub-module sync_fifo (WIDTH=LANES*DATA_W, DEPTH): async active-high rst, sync flush, outputs full/empty/head.

Test Plan (DATA_W=16, LANES=2, DEPTH=4, TOL=1, SIGNED=1, TIMEOUT=16):
- Reset/clear: assert rst mid-RUN with 3 entries queued -> all outputs 0, FIFO empty, exp_ready=1 one cycle after release; repeat with clear -> same result.
- Exact match: push {0x0003,0x0010}×3, then 3 matching act beats, then finish -> err_data=0 each beat, err_valid one cycle after each act_valid, sample_cnt=3, mismatch_cnt=0, done=1, pass=1.
- Tolerance/wrap:
  - exp 0x0005 vs act 0x0004 -> err 0x0001, no mismatch.
  - exp 0x0005 vs act 0x0002 -> err 0x0003, mismatch, max_abs_err=3.
  - exp 0x7FFF vs act 0x8000 -> err_data 0xFFFF, abs 0xFFFF, max_abs_err=0x0FFFF.
  - Rerun with SIGNED=0, same 0x7FFF/0x8000 pair -> abs 1, no mismatch.
- Full/simultaneous: 5 back-to-back pushes -> 5th stalls with exp_ready=0; an act pop frees a slot and the 5th is accepted the next cycle; push+pop at occupancy 2 -> occupancy stays 2, FIFO order preserved.
- Underflow: act_valid with FIFO empty -> underflow=1, sample_cnt unchanged; later finish -> done=1, pass=0.
- Timeout: 2 entries queued, finish, no act for 16 cycles -> done=1 on cycle 16, timeout=1, pass=0; an act beat on cycle 10 resets the count and pops one entry.
